// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; LSB-first frames of DBITS data and SBITS stop bits,
// delivered on dout with a one-cycle rx_done strobe and a stop-bit error flag.
module uart_rx #(
    parameter int DBITS = 8,
    parameter int SBITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             s_tick,
    output logic [DBITS-1:0] dout,
    output logic             rx_done,
    output logic             frame_err,
    output logic             rx_idle
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [3:0] DLAST = 4'(DBITS - 1);
    localparam logic [3:0] SLAST = 4'(SBITS - 1);
    state_t state, state_n;
    logic rx_m, rx_s;
    logic [3:0] t, t_n, n, n_n;
    logic [DBITS-1:0] b, b_n, dout_n;
    logic ferr, ferr_n, done_n, fe_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            state <= IDLE;
            t <= '0;
            n <= '0;
            b <= '0;
            ferr <= 1'b0;
            dout <= '0;
            rx_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            state <= state_n;
            t <= t_n;
            n <= n_n;
            b <= b_n;
            ferr <= ferr_n;
            dout <= dout_n;
            rx_done <= done_n;
            frame_err <= fe_n;
        end
    end

    assign rx_idle = state == IDLE;

    always_comb begin
        state_n = state;
        t_n = t;
        n_n = n;
        b_n = b;
        ferr_n = ferr;
        dout_n = dout;
        done_n = 1'b0;
        fe_n = frame_err;
        case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                t_n = '0;
                ferr_n = 1'b0;
            end
            START: if (s_tick) begin
                if (t == 4'd7) begin
                    state_n = rx_s ? IDLE : DATA;
                    t_n = '0;
                    n_n = '0;
                end else t_n = t + 4'd1;
            end
            DATA: if (s_tick) begin
                if (t == 4'd15) begin
                    b_n = {rx_s, b[DBITS-1:1]};
                    t_n = '0;
                    state_n = (n == DLAST) ? STOP : DATA;
                    n_n = (n == DLAST) ? 4'd0 : n + 4'd1;
                end else t_n = t + 4'd1;
            end
            STOP: if (s_tick) begin
                if (t == 4'd15) begin
                    // the error seen on this last stop sample must reach frame_err in the same frame
                    ferr_n = ferr | ~rx_s;
                    if (n == SLAST) begin
                        state_n = IDLE;
                        done_n = 1'b1;
                        dout_n = b;
                        fe_n = ferr_n;
                    end else begin
                        n_n = n + 4'd1;
                        t_n = '0;
                    end
                end else t_n = t + 4'd1;
            end
        endcase
    end
endmodule
